// File: rtl/mul_err_pkg.sv
// Shared constants for the approximate-multiplier error sweep: default operand width,
// derived widths and sequencer state encodings.
package mul_err_pkg;

  localparam int unsigned DefW = 6;
  localparam int unsigned PW   = 2 * DefW;
  localparam int unsigned CW   = 2 * DefW + 1;
  localparam int unsigned SUMW = 4 * DefW;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/mul_err_acc.sv
// Stage-2 error accumulator: count, sum and max |err| with first worst-case operands.
// Optional signed bias accumulator when MUL_ERR_BIAS_EN is defined.
module mul_err_acc
  import mul_err_pkg::*;
#(
  parameter int unsigned W    = DefW,
  parameter int unsigned SUMW = 4 * W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [W-1:0]      a_i,
  input  logic [W-1:0]      b_i,
  input  logic [2*W-1:0]    exact_i,
  input  logic [2*W-1:0]    apx_i,
  output logic [2*W:0]      err_count_o,
  output logic [2*W-1:0]    err_max_o,
  output logic [SUMW-1:0]   err_sum_o,
  output logic [W-1:0]      worst_a_o,
`ifdef MUL_ERR_BIAS_EN
  output logic signed [SUMW:0] err_bias_o,
`endif
  output logic [W-1:0]      worst_b_o
);

  localparam int unsigned ProdW = 2 * W;
  localparam int unsigned CntW  = 2 * W + 1;

  logic [CntW-1:0]  count_q, count_d;
  logic [ProdW-1:0] max_q, max_d;
  logic [SUMW-1:0]  sum_q, sum_d;
  logic [W-1:0]     wa_q, wa_d, wb_q, wb_d;
  logic [CntW-1:0]  diff_wide;
  logic [ProdW-1:0] abs_err;

  always_comb begin
    if (exact_i >= apx_i) diff_wide = {1'b0, exact_i} - {1'b0, apx_i};
    else                  diff_wide = {1'b0, apx_i} - {1'b0, exact_i};
    abs_err = diff_wide[CntW-1] ? {ProdW{1'b1}} : diff_wide[ProdW-1:0];
  end

  always_comb begin
    count_d = count_q;
    max_d   = max_q;
    sum_d   = sum_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    if (clr_i) begin
      count_d = '0;
      max_d   = '0;
      sum_d   = '0;
      wa_d    = '0;
      wb_d    = '0;
    end else if (en_i) begin
      if (abs_err != '0) count_d = count_q + CntW'(1);
      sum_d = sum_q + {{(SUMW-ProdW){1'b0}}, abs_err};
      // Strict compare keeps the earliest pair on ties.
      if (abs_err > max_q) begin
        max_d = abs_err;
        wa_d  = a_i;
        wb_d  = b_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
    end else begin
      count_q <= count_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
    end
  end

  assign err_count_o = count_q;
  assign err_max_o   = max_q;
  assign err_sum_o   = sum_q;
  assign worst_a_o   = wa_q;
  assign worst_b_o   = wb_q;

`ifdef MUL_ERR_BIAS_EN
  logic signed [SUMW:0] bias_q, bias_d;
  logic signed [CntW-1:0] sdiff;
  logic signed [SUMW:0] sdiff_ext;

  always_comb begin
    sdiff     = $signed({1'b0, apx_i}) - $signed({1'b0, exact_i});
    sdiff_ext = {{(SUMW+1-CntW){sdiff[CntW-1]}}, sdiff};
    bias_d    = bias_q;
    if (clr_i)     bias_d = '0;
    else if (en_i) bias_d = bias_q + sdiff_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bias_q <= '0;
    else     bias_q <= bias_d;
  end

  assign err_bias_o = bias_q;
`endif

endmodule

// File: rtl/mul_err_sweep_ctrl.sv
// Exhaustive sweep sequencer for an external combinational WxW approximate multiplier.
// Define MUL_ERR_BIAS_EN to add the signed err_bias output.
module mul_err_sweep_ctrl
  import mul_err_pkg::*;
#(
  parameter int unsigned W    = DefW,
  parameter int unsigned SUMW = 4 * W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [W-1:0]        op_a,
  output logic [W-1:0]        op_b,
  input  logic [2*W-1:0]      prod_apx,
  output logic                busy,
  output logic                done,
  output logic                res_valid,
  output logic [2*W:0]        err_count,
  output logic [2*W-1:0]      err_max,
  output logic [SUMW-1:0]     err_sum,
  output logic [W-1:0]        worst_a,
`ifdef MUL_ERR_BIAS_EN
  output logic signed [SUMW:0] err_bias,
`endif
  output logic [W-1:0]        worst_b
);

  localparam int unsigned ProdW = 2 * W;

  logic [1:0]       state_q, state_d;
  logic [ProdW-1:0] idx_q, idx_d;
  logic             res_valid_q, res_valid_d;
  logic             acc_clr;

  logic             v1_q, v1_d;
  logic [W-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ProdW-1:0] s1_exact_q, s1_exact_d, s1_apx_q, s1_apx_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    res_valid_d = res_valid_q;
    acc_clr     = 1'b0;
    case (state_q)
      StIdle: begin
        if (abort) begin
          res_valid_d = 1'b0;
        end else if (start) begin
          state_d     = StSweep;
          idx_d       = '0;
          res_valid_d = 1'b0;
          acc_clr     = 1'b1;
        end
      end
      StSweep: begin
        if (abort) begin
          state_d     = StIdle;
          res_valid_d = 1'b0;
        end else if (idx_q == {ProdW{1'b1}}) begin
          // Final pair stays on the operand bus through DRAIN.
          state_d = StDrain;
        end else begin
          idx_d = idx_q + ProdW'(1);
        end
      end
      StDrain: begin
        if (abort) begin
          state_d     = StIdle;
          res_valid_d = 1'b0;
        end else begin
          state_d     = StDone;
          res_valid_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (abort) res_valid_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    v1_d       = (state_q == StSweep) && !abort;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_exact_d = s1_exact_q;
    s1_apx_d   = s1_apx_q;
    if (state_q == StSweep) begin
      s1_a_d     = op_a;
      s1_b_d     = op_b;
      s1_exact_d = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
      s1_apx_d   = prod_apx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      v1_q        <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_exact_q  <= '0;
      s1_apx_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      res_valid_q <= res_valid_d;
      v1_q        <= v1_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_exact_q  <= s1_exact_d;
      s1_apx_q    <= s1_apx_d;
    end
  end

  assign op_a      = idx_q[ProdW-1:W];
  assign op_b      = idx_q[W-1:0];
  assign busy      = (state_q == StSweep) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign res_valid = res_valid_q;

  mul_err_acc #(
    .W    (W),
    .SUMW (SUMW)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (acc_clr),
    .en_i        (v1_q),
    .a_i         (s1_a_q),
    .b_i         (s1_b_q),
    .exact_i     (s1_exact_q),
    .apx_i       (s1_apx_q),
    .err_count_o (err_count),
    .err_max_o   (err_max),
    .err_sum_o   (err_sum),
    .worst_a_o   (worst_a),
`ifdef MUL_ERR_BIAS_EN
    .err_bias_o  (err_bias),
`endif
    .worst_b_o   (worst_b)
  );

endmodule
